xoodoo_arbiter: RTL

- Shares one Xoodoo permutation core between NUM_REQ XOODYAK-style requesters (hash/AEAD lanes).
- Each requester issues a one-cycle enable pulse with a 384-bit state. The arbiter latches it, grants the core round-robin, runs one permutation and returns the permuted state with a one-cycle done pulse.
- Sits between the lane controllers and the single xoodoo core instance.

---
 rtl/xoodoo_pkg.sv | 14 +
 rtl/xoodoo_arbiter_if.sv | 33 +++
 rtl/xoodoo_rr_pick.sv | 27 ++
 rtl/xoodoo_arbiter.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/xoodoo_pkg.sv
// Shared constants and FSM encoding for the Xoodoo core arbiter.
package xoodoo_pkg;

    localparam int unsigned XOODOO_STATE_W = 384;
    localparam int unsigned XOODOO_TIMEOUT = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } arb_state_e;

endpackage

// File: rtl/xoodoo_arbiter_if.sv
// Lane-side and core-side signals of the shared Xoodoo core arbiter.
interface xoodoo_arbiter_if
    import xoodoo_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned STATE_W = XOODOO_STATE_W
);

    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*STATE_W-1:0] req_state;
    logic [NUM_REQ-1:0]         resp_done;
    logic [STATE_W-1:0]         resp_state;
    logic                       core_start;
    logic [STATE_W-1:0]         core_state_out;
    logic                       core_done;
    logic [STATE_W-1:0]         core_state_in;
    logic                       busy;
    logic [NUM_REQ-1:0]         overrun_err;
    logic                       timeout_err;

    modport slave (
        input  req_valid, req_state, core_done, core_state_in,
        output resp_done, resp_state, core_start, core_state_out,
               busy, overrun_err, timeout_err
    );

    modport master (
        output req_valid, req_state, core_done, core_state_in,
        input  resp_done, resp_state, core_start, core_state_out,
               busy, overrun_err, timeout_err
    );

endinterface

// File: rtl/xoodoo_rr_pick.sv
// Combinational round-robin picker: first pending lane after rr_ptr, wrapping.
module xoodoo_rr_pick #(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         pending_i,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr_i,
    output logic [$clog2(NUM_REQ)-1:0] grant_o,
    output logic                       any_o
);

    localparam int unsigned GW = $clog2(NUM_REQ);

    always_comb begin
        int unsigned idx;
        idx     = 0;
        grant_o = '0;
        any_o   = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = (32'(rr_ptr_i) + k) % NUM_REQ;
            if (!any_o && pending_i[GW'(idx)]) begin
                grant_o = GW'(idx);
                any_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xoodoo_arbiter.sv
// Round-robin sharing of one Xoodoo permutation core between NUM_REQ lanes.
module xoodoo_arbiter
    import xoodoo_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned STATE_W = XOODOO_STATE_W,
    parameter int unsigned TIMEOUT = XOODOO_TIMEOUT
) (
    input  logic            clk,
    input  logic            reset,
    xoodoo_arbiter_if.slave bus
);

    localparam int unsigned GW = $clog2(NUM_REQ);
    localparam int unsigned TW = $clog2(TIMEOUT);

    arb_state_e         state_q, state_d;
    logic [GW-1:0]      grant_q, grant_d;
    logic [GW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]      pick_idx;
    logic               any_pending;
    logic [TW-1:0]      timer_q, timer_d;
    logic [NUM_REQ-1:0] pending_q, pending_d;
    logic [NUM_REQ-1:0] overrun_q, overrun_d;
    logic [NUM_REQ-1:0] resp_done_q, resp_done_d;
    logic [NUM_REQ-1:0] capture;
    logic [STATE_W-1:0] buf_q [NUM_REQ];
    logic [STATE_W-1:0] core_state_q, core_state_d;
    logic [STATE_W-1:0] resp_state_q, resp_state_d;
    logic               core_start_q, core_start_d;
    logic               timeout_q, timeout_d;
    logic               busy_q, busy_d;
    logic               release_grant;

    xoodoo_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .pending_i (pending_q),
        .rr_ptr_i  (rr_ptr_q),
        .grant_o   (pick_idx),
        .any_o     (any_pending)
    );

    always_comb begin
        pending_d = pending_q;
        overrun_d = overrun_q;
        capture   = '0;
        if (release_grant) begin
            pending_d[grant_q] = 1'b0;
        end
        // the lane being answered this cycle may queue its next request
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (bus.req_valid[i]) begin
                if (!pending_q[i] || (state_q == ST_RESP && grant_q == GW'(i))) begin
                    pending_d[i] = 1'b1;
                    capture[i]   = 1'b1;
                end else begin
                    overrun_d[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        timer_d       = timer_q;
        core_state_d  = core_state_q;
        resp_state_d  = resp_state_q;
        release_grant = 1'b0;
        timeout_d     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (any_pending) begin
                    grant_d      = pick_idx;
                    core_state_d = buf_q[pick_idx];
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.core_done) begin
                    resp_state_d = bus.core_state_in;
                    state_d      = ST_RESP;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    timeout_d     = 1'b1;
                    release_grant = 1'b1;
                    rr_ptr_d      = grant_q;
                    state_d       = ST_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_RESP: begin
                release_grant = 1'b1;
                rr_ptr_d      = grant_q;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Moore outputs are registered from the state being entered
        core_start_d = (state_d == ST_ISSUE);
        busy_d       = (state_d != ST_IDLE);
        resp_done_d  = '0;
        if (state_d == ST_RESP) begin
            resp_done_d[grant_d] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            rr_ptr_q     <= GW'(NUM_REQ - 1);
            timer_q      <= '0;
            pending_q    <= '0;
            overrun_q    <= '0;
            resp_done_q  <= '0;
            core_state_q <= '0;
            resp_state_q <= '0;
            core_start_q <= 1'b0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            timer_q      <= timer_d;
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
            resp_done_q  <= resp_done_d;
            core_state_q <= core_state_d;
            resp_state_q <= resp_state_d;
            core_start_q <= core_start_d;
            timeout_q    <= timeout_d;
            busy_q       <= busy_d;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (capture[i]) begin
                    buf_q[i] <= bus.req_state[i*STATE_W +: STATE_W];
                end
            end
        end
    end

    assign bus.resp_done      = resp_done_q;
    assign bus.resp_state     = resp_state_q;
    assign bus.core_start     = core_start_q;
    assign bus.core_state_out = core_state_q;
    assign bus.busy           = busy_q;
    assign bus.overrun_err    = overrun_q;
    assign bus.timeout_err    = timeout_q;

endmodule
